// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// Grants one byte at a time, waits for tx_done or a watchdog, then holds an idle gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic [ID_W-1:0]           grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [15:0]         cnt, cnt_d;
  logic [ID_W-1:0]     grant_d;
  logic [DATA_W-1:0]   tx_data_d;
  logic [NUM_REQ-1:0]  ack_d;
  logic                tx_start_d, timeout_err_d, active_d;

  // Winner search: grant_id doubles as last_grant, the search starts one past it.
  logic                found;
  logic [ID_W-1:0]     win;
  logic [DATA_W-1:0]   win_data;

  always_comb begin
    found    = 1'b0;
    win      = grant_id;
    win_data = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == (int'(grant_id) + k) % NUM_REQ)) begin
          found = 1'b1;
          win   = ID_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    grant_d       = grant_id;
    tx_data_d     = tx_data;
    ack_d         = '0;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          tx_data_d  = win_data;
          ack_d      = NUM_REQ'(1) << win;
          tx_start_d = 1'b1;
          grant_d    = win;
          cnt_d      = '0;
          state_d    = XMIT;
        end
      end
      XMIT: begin
        cnt_d = cnt + 16'd1;
        // tx_done takes priority over a watchdog expiring on the same cycle.
        if (tx_done) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = GAP;
          cnt_d         = '0;
        end
      end
      GAP: begin
        cnt_d = cnt + 16'd1;
        if (cnt == 16'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      grant_id    <= ID_W'(NUM_REQ - 1);
      tx_data     <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      grant_id    <= grant_d;
      tx_data     <= tx_data_d;
      ack         <= ack_d;
      tx_start    <= tx_start_d;
      timeout_err <= timeout_err_d;
      active      <= active_d;
    end
  end

endmodule
